wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
// - Writeback stage of the RV32 pipeline. Directly upstream of the register file: drives its en/wa/wd write port.
// - Accepts one retiring instruction per cycle from MEM over a valid/ready handshake.
// - Waits for load data and aligns/extends it. Selects the writeback source.
// - Exports the value being written so the hazard unit can forward it.
// PARAMETERS
// - XLEN       32  datapath width
// - RA_W       5   register address width (32 architectural registers)
// - INSTRET_W  64  retire counter width (only with WB_INSTRET_EN)
// PORTS
// - clk         in   1      rising-edge clock
// - rst_n       in   1      asynchronous active-low reset
// - in_valid    in   1      MEM presents a retiring instruction
// - in_ready    out  1      wb_stage accepts this cycle
// - in_rd       in   RA_W   destination register
// - in_reg_wr   in   1      instruction writes rd
// - in_wb_sel   in   2      0=ALU 1=LOAD 2=PC+4 3=IMM
// - in_alu      in   XLEN   ALU result
// - in_pc4      in   XLEN   PC+4
// - in_imm      in   XLEN   U-type immediate
// - in_size     in   2      load size: 0=byte 1=half 2=word
// - in_uns      in   1      zero-extend load
// - in_alo      in   2      load address bits [1:0]
// - ld_valid    in   1      data memory returns load data
// - ld_data     in   XLEN   raw aligned-word load data
// - rf_en       out  1      register-file write enable
// - rf_wa       out  RA_W   register-file write address
// - rf_wd       out  XLEN   register-file write data
// - fwd_valid   out  1      equals rf_en (forward source live)
// - fwd_rd      out  RA_W   equals rf_wa
// - fwd_data    out  XLEN   equals rf_wd
// - instret     out  INSTRET_W  retired count (WB_INSTRET_EN only)
// BEHAVIOUR
// - FSM states: IDLE, WAIT_LD, COMMIT. Reset -> IDLE.
// - Reset values: rf_en=0, rf_wa=0, rf_wd=0, fwd_*=0, instret=0.
// - in_ready = (state != WAIT_LD). Accept = in_valid & in_ready; accepted fields are registered.
// - Accept with wb_sel!=LOAD -> COMMIT next cycle.
// - Accept with wb_sel==LOAD -> WAIT_LD. Stay until ld_valid. Capture aligned data -> COMMIT next cycle.
// - ld_valid outside WAIT_LD is ignored. Load data never arrives in the accept cycle.
// - COMMIT drives outputs for exactly one cycle:
//   - rf_en = reg_wr & (rd!=0); rf_wa = rd; rf_wd = selected value.
//   - Accept in COMMIT -> COMMIT or WAIT_LD per the new op; otherwise -> IDLE.
//   - Back-to-back throughput: 1 per cycle for non-loads. Latency is 1 cycle accept->write, or 1 cycle after ld_valid.
// - Outside COMMIT, rf_en=0. rf_wa and rf_wd hold their last values.
// - Load align, with s = ld_data >> (8*in_alo):
//   - byte: s[7:0], sign- or zero-extended per in_uns.
//   - half: s[15:0] using in_alo[1] only (alo[0] ignored), extended per in_uns.
//   - word: ld_data unchanged; alo ignored.
//   - in_size=3 is treated as word.
// - rd==0 never asserts rf_en, even with reg_wr=1.
// - Reset asserted mid-WAIT_LD or mid-COMMIT: immediate IDLE. Pending op dropped; no write.
// CONFIGURATION
// - WB_INSTRET_EN defined:
//   - instret increments by 1 on every COMMIT cycle, including rd==0 and reg_wr=0; wraps at 2^INSTRET_W.
// - WB_INSTRET_EN undefined:
//   - instret port and counter are absent.
// STRUCTURE
// - Shared package rv_pkg:
//   - wb_sel_e {WB_ALU, WB_LOAD, WB_PC4, WB_IMM}
//   - ld_size_e {LD_B, LD_H, LD_W}
//   - XLEN, RA_W constants
//   - wb_state_e
// - One sub-module: load_align (combinational size/offset/extension).
// TESTING
// - ALU op rd=5, alu=0x1234_5678, reg_wr=1 -> next cycle rf_en=1, wa=5, wd=0x1234_5678.
// - LB alo=2, uns=0, ld_data=0x0080_0000 after 3 wait cycles:
//   - in_ready=0 during wait; write 0xFFFF_FF80 one cycle after ld_valid.
// - LHU alo=2, ld_data=0xBEEF_0000 -> wd=0x0000_BEEF.
// - rd=0, reg_wr=1 -> rf_en stays 0; instret still +1 with WB_INSTRET_EN.
// - 4 back-to-back ALU ops -> 4 consecutive rf_en cycles; in_ready held 1.
// - rst_n low during WAIT_LD -> FSM in IDLE, no write after release; a stray ld_valid is ignored.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 pipeline types and constants used by the writeback stage.
package rv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RA_W      = 5;
  localparam int unsigned INSTRET_W = 64;

  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_IMM} wb_sel_e;
  typedef enum logic [1:0] {LD_B, LD_H, LD_W} ld_size_e;
  typedef enum logic [1:0] {StIdle, StWaitLd, StCommit} wb_state_e;

  // Non-load writeback source; WB_LOAD never reaches here.
  function automatic logic [XLEN-1:0] wb_select(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] alu,
                                                input logic [XLEN-1:0] pc4,
                                                input logic [XLEN-1:0] imm);
    case (wb_sel_e'(sel))
      WB_PC4:  return pc4;
      WB_IMM:  return imm;
      default: return alu;
    endcase
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB handshake, load return, and register-file / forwarding port bundle.
interface wb_stage_if;
  import rv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [RA_W-1:0] in_rd;
  logic            in_reg_wr;
  logic [1:0]      in_wb_sel;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_pc4;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_size;
  logic            in_uns;
  logic [1:0]      in_alo;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            rf_en;
  logic [RA_W-1:0] rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic            fwd_valid;
  logic [RA_W-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output in_valid, in_rd, in_reg_wr, in_wb_sel, in_alu, in_pc4, in_imm,
           in_size, in_uns, in_alo, ld_valid, ld_data,
    input  in_ready, rf_en, rf_wa, rf_wd, fwd_valid, fwd_rd, fwd_data
  );

  modport slave (
    input  in_valid, in_rd, in_reg_wr, in_wb_sel, in_alu, in_pc4, in_imm,
           in_size, in_uns, in_alo, ld_valid, ld_data,
    output in_ready, rf_en, rf_wa, rf_wd, fwd_valid, fwd_rd, fwd_data
  );

endinterface

// File: rtl/load_align.sv
// Combinational load data alignment and sign/zero extension.
module load_align
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_size,
  input  logic            i_uns,
  input  logic [1:0]      i_alo,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_data[{i_alo, 3'b000} +: 8];
  // Halfword uses only the upper offset bit.
  assign w_half = i_data[{i_alo[1], 4'b0000} +: 16];

  always_comb begin
    o_data = i_data;
    case (ld_size_e'(i_size))
      LD_B:    o_data = {{(XLEN-8){~i_uns & w_byte[7]}}, w_byte};
      LD_H:    o_data = {{(XLEN-16){~i_uns & w_half[15]}}, w_half};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32 writeback stage: accepts retiring ops, waits for loads, drives the RF write port.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module wb_stage
  import rv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  wb_stage_if.slave            bus
`ifdef WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  wb_state_e       r_state;
  logic [RA_W-1:0] r_rd;
  logic            r_reg_wr;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [1:0]      r_alo;
  logic            r_rf_en;
  logic [RA_W-1:0] r_rf_wa;
  logic [XLEN-1:0] r_rf_wd;

  logic            w_ready;
  logic            w_accept;
  logic [XLEN-1:0] w_ld_aligned;

  assign w_ready  = (r_state != StWaitLd);
  assign w_accept = bus.in_valid & w_ready;

  load_align u_load_align (
    .i_data (bus.ld_data),
    .i_size (r_size),
    .i_uns  (r_uns),
    .i_alo  (r_alo),
    .o_data (w_ld_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_rd     <= '0;
      r_reg_wr <= 1'b0;
      r_size   <= '0;
      r_uns    <= 1'b0;
      r_alo    <= '0;
      r_rf_en  <= 1'b0;
      r_rf_wa  <= '0;
      r_rf_wd  <= '0;
    end else begin
      r_rf_en <= 1'b0;
      case (r_state)
        StWaitLd: begin
          if (bus.ld_valid) begin
            r_state <= StCommit;
            r_rf_en <= r_reg_wr & (|r_rd);
            r_rf_wa <= r_rd;
            r_rf_wd <= w_ld_aligned;
          end
        end
        default: begin
          if (w_accept) begin
            r_rd     <= bus.in_rd;
            r_reg_wr <= bus.in_reg_wr;
            if (bus.in_wb_sel == WB_LOAD) begin
              r_state <= StWaitLd;
              r_size  <= bus.in_size;
              r_uns   <= bus.in_uns;
              r_alo   <= bus.in_alo;
            end else begin
              r_state <= StCommit;
              r_rf_en <= bus.in_reg_wr & (|bus.in_rd);
              r_rf_wa <= bus.in_rd;
              r_rf_wd <= wb_select(bus.in_wb_sel, bus.in_alu, bus.in_pc4, bus.in_imm);
            end
          end else begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (r_state == StCommit) begin
      r_instret <= r_instret + INSTRET_W'(1);
    end
  end

  assign instret = r_instret;
`endif

  assign bus.in_ready  = w_ready;
  assign bus.rf_en     = r_rf_en;
  assign bus.rf_wa     = r_rf_wa;
  assign bus.rf_wd     = r_rf_wd;
  assign bus.fwd_valid = r_rf_en;
  assign bus.fwd_rd    = r_rf_wa;
  assign bus.fwd_data  = r_rf_wd;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: transaction-level model plus directed literal checks.
module tb_wb_stage;
  import rv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if bus ();
`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] instret;
`endif

  wb_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_INSTRET_EN
    ,
    .instret (instret)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: outstanding load, pending commit, and expected visible outputs.
  bit         pend = 1'b0;
  logic [4:0] p_rd;
  bit         p_wr;
  logic [1:0] p_size, p_alo;
  bit         p_uns;
  bit         commit_nx = 1'b0;
  logic [4:0] c_rd;
  bit         c_wr;
  logic [31:0] c_val;
  bit          exp_en = 1'b0;
  bit          exp_ready = 1'b1;
  logic [4:0]  exp_wa = '0;
  logic [31:0] exp_wd = '0;
`ifdef WB_INSTRET_EN
  logic [63:0] exp_ir = '0;
  bit          was_commit = 1'b0;
`endif

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_align(input logic [31:0] d, input logic [1:0] size,
                                              input bit uns, input logic [1:0] alo);
    logic [31:0] s;
    if (size == 2'd0) begin
      s = d >> (8 * alo);
      return uns ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    end
    if (size == 2'd1) begin
      s = d >> (alo[1] ? 16 : 0);
      return uns ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    end
    return d;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("rf_en", 64'(bus.rf_en), 64'(exp_en));
      check("rf_wa", 64'(bus.rf_wa), 64'(exp_wa));
      check("rf_wd", 64'(bus.rf_wd), 64'(exp_wd));
      check("fwd_valid", 64'(bus.fwd_valid), 64'(exp_en));
      check("fwd_rd", 64'(bus.fwd_rd), 64'(exp_wa));
      check("fwd_data", 64'(bus.fwd_data), 64'(exp_wd));
      check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
`ifdef WB_INSTRET_EN
      check("instret", 64'(instret), exp_ir);
`endif
    end
  end

  // Drive one cycle of inputs, predict the effect of the coming edge, land at posedge+1.
  task automatic cycle(input bit v, input logic [4:0] rd, input bit wr, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [1:0] size, input bit uns, input logic [1:0] alo,
                       input bit ldv, input logic [31:0] ldd);
    bus.in_valid  = v;
    bus.in_rd     = rd;
    bus.in_reg_wr = wr;
    bus.in_wb_sel = sel;
    bus.in_alu    = alu;
    bus.in_pc4    = pc4;
    bus.in_imm    = imm;
    bus.in_size   = size;
    bus.in_uns    = uns;
    bus.in_alo    = alo;
    bus.ld_valid  = ldv;
    bus.ld_data   = ldd;
    commit_nx = 1'b0;
    if (pend) begin
      if (ldv) begin
        commit_nx = 1'b1;
        c_rd  = p_rd;
        c_wr  = p_wr;
        c_val = model_align(ldd, p_size, p_uns, p_alo);
        pend  = 1'b0;
      end
    end else if (v) begin
      if (sel == 2'd1) begin
        pend = 1'b1; p_rd = rd; p_wr = wr; p_size = size; p_uns = uns; p_alo = alo;
      end else begin
        commit_nx = 1'b1;
        c_rd  = rd;
        c_wr  = wr;
        c_val = (sel == 2'd0) ? alu : (sel == 2'd2) ? pc4 : imm;
      end
    end
    @(posedge clk);
    #1;
`ifdef WB_INSTRET_EN
    if (was_commit) exp_ir++;
    was_commit = commit_nx;
`endif
    exp_en = commit_nx && c_wr && (c_rd != 5'd0);
    if (commit_nx) begin
      exp_wa = c_rd;
      exp_wd = c_val;
    end
    exp_ready = !pend;
  endtask

  task automatic idle_cycle(input bit ldv, input logic [31:0] ldd);
    cycle(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, ldv, ldd);
  endtask

  // Asynchronous reset asserted between edges; a stray ld_valid is held meanwhile.
  task automatic do_reset();
    rst_n = 1'b0;
    pend = 1'b0; commit_nx = 1'b0;
    exp_en = 1'b0; exp_wa = '0; exp_wd = '0; exp_ready = 1'b1;
`ifdef WB_INSTRET_EN
    exp_ir = '0; was_commit = 1'b0;
`endif
    bus.in_valid = 1'b0;
    bus.ld_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_reg_wr = 1'b0; bus.in_wb_sel = '0;
    bus.in_alu = '0; bus.in_pc4 = '0; bus.in_imm = '0; bus.in_size = '0;
    bus.in_uns = 1'b0; bus.in_alo = '0; bus.ld_valid = 1'b0; bus.ld_data = '0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lit_rst_en", 64'(bus.rf_en), 64'd0);
    check("lit_rst_wd", 64'(bus.rf_wd), 64'd0);
    check("lit_rst_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    // ALU op
    cycle(1'b1, 5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0);
    check("lit_alu_en", 64'(bus.rf_en), 64'd1);
    check("lit_alu_wa", 64'(bus.rf_wa), 64'd5);
    check("lit_alu_wd", 64'(bus.rf_wd), 64'h1234_5678);

    // LB alo=2 signed, three wait cycles
    cycle(1'b1, 5'd7, 1'b1, 2'd1, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd2, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("lit_lb_ready", 64'(bus.in_ready), 64'd0);
      check("lit_lb_noen", 64'(bus.rf_en), 64'd0);
      idle_cycle(1'b0, 32'h0);
    end
    idle_cycle(1'b1, 32'h0080_0000);
    check("lit_lb_en", 64'(bus.rf_en), 64'd1);
    check("lit_lb_wd", 64'(bus.rf_wd), 64'hFFFF_FF80);

    // LHU alo=2
    cycle(1'b1, 5'd9, 1'b1, 2'd1, 32'h0, 32'h0, 32'h0, 2'd1, 1'b1, 2'd2, 1'b0, 32'h0);
    idle_cycle(1'b1, 32'hBEEF_0000);
    check("lit_lhu_wd", 64'(bus.rf_wd), 64'h0000_BEEF);

    // rd=0 never writes
    cycle(1'b1, 5'd0, 1'b1, 2'd3, 32'h0, 32'h0, 32'hABCD_0000, 2'd0, 1'b0, 2'd0, 1'b0, 32'h0);
    check("lit_rd0_en", 64'(bus.rf_en), 64'd0);

    // Four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'(i + 1), 1'b1, 2'd0, 32'(i * 3 + 1), 32'h0, 32'h0, 2'd0, 1'b0, 2'd0,
            1'b0, 32'h0);
      check("lit_b2b_en", 64'(bus.rf_en), 64'd1);
      check("lit_b2b_ready", 64'(bus.in_ready), 64'd1);
    end
    idle_cycle(1'b0, 32'h0);

    // Reset during WAIT_LD, then a stray ld_valid
    cycle(1'b1, 5'd11, 1'b1, 2'd1, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0, 2'd0, 1'b0, 32'h0);
    idle_cycle(1'b0, 32'h0);
    do_reset();
    idle_cycle(1'b1, 32'hDEAD_BEEF);
    check("lit_rst_ld_en", 64'(bus.rf_en), 64'd0);
    check("lit_rst_ld_ready", 64'(bus.in_ready), 64'd1);
    idle_cycle(1'b0, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit ldv;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        ldv = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
        cycle($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), 2'($urandom),
              $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom), 2'($urandom),
              ldv, $urandom);
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
